traffic_sensor_cond: RTL



---
 rtl/traffic_sensor_cond_pkg.sv | 21 ++
 rtl/traffic_sensor_cond_lane.sv | 129 ++++++++++++
 rtl/traffic_sensor_cond.sv | 75 +++++++
 3 files changed

// File: rtl/traffic_sensor_cond_pkg.sv
// -----------------------------------------------------------------------------
// traffic_sensor_cond_pkg
// Shared definitions for the traffic sensor conditioner.
//   lane_state_e : per-lane presence state (idle / present / hold)
//   cnt_w()      : counter width helper that never returns less than 1 bit
// -----------------------------------------------------------------------------
package traffic_sensor_cond_pkg;

   typedef enum logic [1:0] {
      LANE_IDLE    = 2'd0,
      LANE_PRESENT = 2'd1,
      LANE_HOLD    = 2'd2
   } lane_state_e;

   // Bits needed to hold values 0..n-1; a zero-width counter is not legal, so
   // degenerate cases (n <= 1) still get one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/traffic_sensor_cond_lane.sv
// -----------------------------------------------------------------------------
// sensor_lane
// One detector lane: 2-flop synchroniser, tick-based debounce, presence hold
// state machine, and registered presence / rising-edge outputs.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   tick       : prescaler strobe that paces debounce and hold counting
//   raw        : asynchronous, bouncy detector input
//   traf       : conditioned presence level (registered)
//   evt        : one-cycle pulse on each 0->1 of traf (registered)
// -----------------------------------------------------------------------------
module sensor_lane
   import traffic_sensor_cond_pkg::*;
#(
   parameter int DEB_TICKS  = 4,
   parameter int HOLD_TICKS = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   output logic traf,
   output logic evt
);

   localparam int DCNT_W = cnt_w(DEB_TICKS);
   localparam int HCNT_W = cnt_w(HOLD_TICKS + 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_TICKS - 1);
   localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD_TICKS);
   localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_deb;
   logic [DCNT_W-1:0] r_dcnt;
   lane_state_e       r_state;
   logic [HCNT_W-1:0] r_hcnt;
   logic              r_traf;
   logic              r_evt;
   logic              w_traf_next;

   // Synchroniser: r_sync2 is the first flop safe to use as logic input.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: the synced input must disagree with r_deb on DEB_TICKS
   // consecutive ticks; any agreeing cycle restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_deb  <= 1'b0;
         r_dcnt <= '0;
      end else if (r_sync2 == r_deb) begin
         r_dcnt <= '0;
      end else if (tick) begin
         if (r_dcnt == DCNT_LAST) begin
            r_deb  <= r_sync2;
            r_dcnt <= '0;
         end else begin
            r_dcnt <= r_dcnt + DCNT_W'(1);
         end
      end
   end

   // Hold state machine: while present the hold counter is kept loaded, so
   // the hold period always starts full when the debounced input falls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LANE_IDLE;
         r_hcnt  <= '0;
      end else begin
         case (r_state)
            LANE_IDLE: begin
               r_hcnt <= '0;
               if (r_deb) begin
                  r_state <= LANE_PRESENT;
                  r_hcnt  <= HCNT_LOAD;
               end
            end
            LANE_PRESENT: begin
               r_hcnt <= HCNT_LOAD;
               if (!r_deb) begin
                  r_state <= (HOLD_TICKS > 0) ? LANE_HOLD : LANE_IDLE;
               end
            end
            LANE_HOLD: begin
               if (r_deb) begin
                  r_state <= LANE_PRESENT;
                  r_hcnt  <= HCNT_LOAD;
               end else if (tick) begin
                  if (r_hcnt <= HCNT_ONE) begin
                     r_hcnt  <= '0;
                     r_state <= LANE_IDLE;
                  end else begin
                     r_hcnt <= r_hcnt - HCNT_ONE;
                  end
               end
            end
            default: begin
               r_state <= LANE_IDLE;
               r_hcnt  <= '0;
            end
         endcase
      end
   end

   // Presence is the debounced level stretched by any remaining hold time.
   assign w_traf_next = r_deb | (r_hcnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_traf <= 1'b0;
         r_evt  <= 1'b0;
      end else begin
         r_traf <= w_traf_next;
         r_evt  <= w_traf_next & ~r_traf;
      end
   end

   assign traf = r_traf;
   assign evt  = r_evt;

endmodule

// File: rtl/traffic_sensor_cond.sv
// -----------------------------------------------------------------------------
// traffic_sensor_cond
// Conditions the two raw vehicle detectors into clean presence levels for the
// two-road traffic-light controller.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   raw_a, raw_b   : asynchronous raw detector inputs, roads A and B
//   traf_a, traf_b : conditioned presence levels
//   evt_a, evt_b   : one-cycle pulse on each rising edge of traf_a / traf_b
//   tick           : prescaler strobe (observation only)
// -----------------------------------------------------------------------------
module traffic_sensor_cond
   import traffic_sensor_cond_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int DEB_TICKS  = 4,
   parameter int HOLD_TICKS = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_a,
   input  logic raw_b,
   output logic traf_a,
   output logic traf_b,
   output logic evt_a,
   output logic evt_b,
   output logic tick
);

   localparam int PCNT_W = cnt_w(TICK_DIV);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

   logic [PCNT_W-1:0] r_pcnt;
   logic              w_tick;

   // Prescaler 0..TICK_DIV-1; the strobe is the terminal count.
   assign w_tick = (r_pcnt == PCNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pcnt <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + PCNT_W'(1);
      end
   end

   assign tick = w_tick;

   sensor_lane #(
      .DEB_TICKS  (DEB_TICKS),
      .HOLD_TICKS (HOLD_TICKS)
   ) u_lane_a (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick),
      .raw   (raw_a),
      .traf  (traf_a),
      .evt   (evt_a)
   );

   sensor_lane #(
      .DEB_TICKS  (DEB_TICKS),
      .HOLD_TICKS (HOLD_TICKS)
   ) u_lane_b (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick),
      .raw   (raw_b),
      .traf  (traf_b),
      .evt   (evt_b)
   );

endmodule
